ps2_mouse_ctrl: RTL and testbench

PS/2 mouse host controller on the memory-mapped I/O bus. After reset it sends the Enable Data Reporting command (0xF4) to the mouse and waits for the 0xFA acknowledge byte. It then receives 3-byte stream-mode movement packets and presents status, X and Y through an addressed read port with a data-available flag.

---
 rtl/ps2_pkg.sv | 10 +
 rtl/ps2_rx_byte.sv | 67 ++++++
 rtl/ps2_mouse_ctrl.sv | 109 ++++++++++
 tb/tb_ps2_mouse_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, protocol bytes and register map for the PS/2 mouse controller.
package ps2_pkg;
  typedef enum logic [2:0] {INHIBIT, REQ, TX, WAIT_ACK, STREAM} state_t;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RESP_ACK = 8'hFA;
  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_X = 2'd1;
  localparam logic [1:0] ADDR_Y = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;
endpackage

// File: rtl/ps2_rx_byte.sv
// ps2_rx_byte: synchronises the PS/2 lines, detects clock falls and deframes 11-bit bytes.
// With PS2_PARITY_CHECK_EN defined, even-parity frames are dropped and flagged on par_err.
module ps2_rx_byte import ps2_pkg::*; #(
  parameter int RX_TIMEOUT = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       fall,
  output logic       byte_valid,
  output logic       par_err,
  output logic [7:0] rx_byte
);
  localparam int TW = $clog2(RX_TIMEOUT + 1);
  logic [2:0] c_sync;
  logic [1:0] d_sync;
  logic [3:0] cnt;
  logic [7:0] sh;
  logic [TW-1:0] to_cnt;
  logic frame_end, d;
  assign d = d_sync[1];
  assign fall = c_sync[2] & ~c_sync[1];
  assign frame_end = en & fall & (cnt == 4'd10);
  assign rx_byte = sh;
`ifdef PS2_PARITY_CHECK_EN
  logic par;
  assign byte_valid = frame_end & ^{par, sh};
  assign par_err = frame_end & ~^{par, sh};
`else
  assign byte_valid = frame_end;
  assign par_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      c_sync <= 3'b111;
      d_sync <= 2'b11;
      cnt <= '0;
      sh <= '0;
      to_cnt <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par <= 1'b0;
`endif
    end else begin
      c_sync <= {c_sync[1:0], ps2_clk};
      d_sync <= {d_sync[0], ps2_data};
      if (!en) begin
        cnt <= '0;
        to_cnt <= '0;
      end else if (fall) begin
        to_cnt <= '0;
        if (cnt == 4'd0) cnt <= {3'b000, ~d};
        else if (cnt == 4'd10) cnt <= '0;
        else begin
          if (cnt != 4'd9) sh <= {d, sh[7:1]};
`ifdef PS2_PARITY_CHECK_EN
          else par <= d;
`endif
          cnt <= cnt + 4'd1;
        end
      end else if (cnt != 4'd0) begin
        to_cnt <= (to_cnt == TW'(RX_TIMEOUT - 1)) ? '0 : to_cnt + TW'(1);
        if (to_cnt == TW'(RX_TIMEOUT - 1)) cnt <= '0;
      end else to_cnt <= '0;
    end
endmodule

// File: rtl/ps2_mouse_ctrl.sv
// ps2_mouse_ctrl: PS/2 mouse host that enables data reporting and latches 3-byte packets.
// Optional PS2_PARITY_CHECK_EN makes the receiver drop bad-parity bytes and set perr.
module ps2_mouse_ctrl import ps2_pkg::*; #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int RX_TIMEOUT = 20000,
  parameter logic [7:0] CMD_BYTE = CMD_ENABLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_cs,
  input  logic [1:0] addr,
  output logic [7:0] data,
  output logic       TCP,
  output logic       t_clk,
  output logic       t_data,
  output logic       m_ack,
  output logic       dav,
  inout  wire        MOUSE_CLOCK,
  inout  wire        MOUSE_DATA
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [15:0] TX_FRAME = {7'h7f, ~^CMD_BYTE, CMD_BYTE};
  state_t state;
  logic [IW-1:0] inh_cnt;
  logic [3:0] tx_cnt;
  logic [1:0] bcnt;
  logic [7:0] stg0, stg1, status, x_reg, y_reg, rx_byte;
  logic perr, fall, byte_valid, par_err, rx_en;
  assign MOUSE_CLOCK = t_clk ? 1'bz : 1'b0;
  assign MOUSE_DATA = t_data ? 1'bz : 1'b0;
  assign rx_en = (state == WAIT_ACK) || (state == STREAM);
  assign data = (addr == ADDR_STATUS) ? status :
                (addr == ADDR_X) ? x_reg :
                (addr == ADDR_Y) ? y_reg : {dav, m_ack, TCP, 4'b0000, perr};
  ps2_rx_byte #(.RX_TIMEOUT(RX_TIMEOUT)) u_rx (
    .clk(clk), .rst(rst), .en(rx_en), .ps2_clk(MOUSE_CLOCK), .ps2_data(MOUSE_DATA),
    .fall(fall), .byte_valid(byte_valid), .par_err(par_err), .rx_byte(rx_byte)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= INHIBIT;
      inh_cnt <= '0;
      tx_cnt <= '0;
      bcnt <= '0;
      t_clk <= 1'b1;
      t_data <= 1'b1;
      TCP <= 1'b0;
      m_ack <= 1'b0;
      dav <= 1'b0;
      perr <= 1'b0;
      stg0 <= '0;
      stg1 <= '0;
      status <= '0;
      x_reg <= '0;
      y_reg <= '0;
    end else begin
      perr <= perr | par_err;
      if (io_cs && addr == ADDR_Y) dav <= 1'b0;
      case (state)
        INHIBIT: begin
          t_clk <= 1'b0;
          t_data <= 1'b1;
          inh_cnt <= inh_cnt + IW'(1);
          if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
            inh_cnt <= '0;
            state <= REQ;
          end
        end
        REQ: begin
          t_clk <= 1'b1;
          t_data <= 1'b0;
          tx_cnt <= '0;
          state <= TX;
        end
        TX: if (fall) begin
          tx_cnt <= tx_cnt + 4'd1;
          if (tx_cnt == 4'd10) begin
            TCP <= 1'b1;
            state <= WAIT_ACK;
          end else t_data <= TX_FRAME[tx_cnt];
        end
        WAIT_ACK: if (byte_valid) begin
          if (rx_byte == RESP_ACK) begin
            m_ack <= 1'b1;
            bcnt <= '0;
            state <= STREAM;
          end else begin
            TCP <= 1'b0;
            m_ack <= 1'b0;
            state <= INHIBIT;
          end
        end
        STREAM: if (par_err) bcnt <= '0;
        else if (byte_valid && (bcnt != 2'd0 || rx_byte[3])) begin
          // byte 0 without the always-one bit is treated as misaligned and dropped
          bcnt <= (bcnt == 2'd2) ? 2'd0 : bcnt + 2'd1;
          if (bcnt == 2'd0) stg0 <= rx_byte;
          if (bcnt == 2'd1) stg1 <= rx_byte;
          if (bcnt == 2'd2) begin
            status <= stg0;
            x_reg <= stg1;
            y_reg <= rx_byte;
            dav <= 1'b1;
          end
        end
        default: state <= INHIBIT;
      endcase
    end
endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// tb_ps2_mouse_ctrl: directed bench acting as a PS/2 mouse against ps2_mouse_ctrl.
module tb_ps2_mouse_ctrl;
  localparam int INH = 20;
  localparam int RX_TO = 100;
  localparam int H = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic io_cs = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] data;
  logic TCP, t_clk, t_data, m_ack, dav;
  logic mc_low = 1'b0;
  logic md_low = 1'b0;
  wire ms_clk, ms_data;
  int total = 0;
  int bad = 0;
  assign ms_clk = mc_low ? 1'b0 : 1'bz;
  assign ms_data = md_low ? 1'b0 : 1'bz;
  pullup (ms_clk);
  pullup (ms_data);
  always #5 clk = ~clk;
  ps2_mouse_ctrl #(.INHIBIT_CYCLES(INH), .RX_TIMEOUT(RX_TO)) dut (
    .clk(clk), .rst(rst), .io_cs(io_cs), .addr(addr), .data(data), .TCP(TCP),
    .t_clk(t_clk), .t_data(t_data), .m_ack(m_ack), .dav(dav),
    .MOUSE_CLOCK(ms_clk), .MOUSE_DATA(ms_data)
  );
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
    addr = a;
    #1;
    check(tag, data, exp);
  endtask
  task automatic send(input logic [7:0] b, input logic flip, input logic start, input int nbits);
    logic [10:0] f;
    f = {1'b1, ~^b ^ flip, b, start};
    for (int i = 0; i < nbits; i++) begin
      md_low = ~f[i];
      repeat (H) @(negedge clk);
      mc_low = 1'b1;
      repeat (H) @(negedge clk);
      mc_low = 1'b0;
    end
    md_low = 1'b0;
    repeat (H) @(negedge clk);
  endtask
  task automatic handshake(input logic chk_len);
    int lows;
    logic [9:0] fr;
    lows = 0;
    fr = {1'b1, 1'b0, 8'hF4};
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!t_clk) lows++;
      else if (lows > 0) break;
    end
    if (chk_len) check("inhibit_len", 8'(lows), 8'(INH));
    check("start_bit", {7'd0, t_data}, 8'd0);
    check("req_clk_released", {7'd0, t_clk}, 8'd1);
    for (int i = 0; i < 11; i++) begin
      repeat (H) @(negedge clk);
      mc_low = 1'b1;
      repeat (H) @(negedge clk);
      if (i < 10) check($sformatf("tx_bit%0d", i), {7'd0, t_data}, {7'd0, fr[i]});
      else check("tcp_after_ack_edge", {7'd0, TCP}, 8'd1);
      mc_low = 1'b0;
    end
    repeat (H) @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    check("rst_t_clk", {7'd0, t_clk}, 8'd1);
    check("rst_t_data", {7'd0, t_data}, 8'd1);
    rd(2'd3, 8'h00, "rst_ctrl");
    rd(2'd0, 8'h00, "rst_status");
    @(negedge clk);
    rst = 1'b0;
    handshake(1'b1);
    send(8'hFE, 1'b0, 1'b0, 11);
    check("nack_tcp_cleared", {7'd0, TCP}, 8'd0);
    check("nack_reinhibit", {7'd0, t_clk}, 8'd0);
    handshake(1'b0);
    send(8'hFA, 1'b0, 1'b0, 11);
    check("m_ack", {7'd0, m_ack}, 8'd1);
    rd(2'd3, 8'h60, "ctrl_after_ack");
    send(8'hAB, 1'b0, 1'b0, 11);
    send(8'hBC, 1'b0, 1'b0, 11);
    check("dav_before_byte2", {7'd0, dav}, 8'd0);
    send(8'hCD, 1'b0, 1'b0, 11);
    check("dav_set", {7'd0, dav}, 8'd1);
    rd(2'd0, 8'hAB, "pkt1_status");
    rd(2'd1, 8'hBC, "pkt1_x");
    rd(2'd2, 8'hCD, "pkt1_y");
    rd(2'd3, 8'hE0, "pkt1_ctrl");
    io_cs = 1'b1;
    addr = 2'd1;
    @(negedge clk);
    io_cs = 1'b0;
    check("dav_kept_addr1", {7'd0, dav}, 8'd1);
    io_cs = 1'b1;
    addr = 2'd2;
    @(negedge clk);
    io_cs = 1'b0;
    check("dav_cleared", {7'd0, dav}, 8'd0);
    rd(2'd3, 8'h60, "ctrl_after_clear");
    send(8'hD0, 1'b0, 1'b0, 11);
    send(8'h28, 1'b0, 1'b0, 11);
    send(8'h11, 1'b0, 1'b0, 11);
    check("resync_no_early_dav", {7'd0, dav}, 8'd0);
    send(8'h22, 1'b0, 1'b0, 11);
    check("resync_dav", {7'd0, dav}, 8'd1);
    rd(2'd0, 8'h28, "pkt2_status");
    rd(2'd1, 8'h11, "pkt2_x");
    rd(2'd2, 8'h22, "pkt2_y");
    send(8'h00, 1'b0, 1'b0, 4);
    repeat (RX_TO + 20) @(negedge clk);
    send(8'hFF, 1'b0, 1'b1, 1);
    send(8'h38, 1'b0, 1'b0, 11);
    send(8'h44, 1'b0, 1'b0, 11);
    send(8'h55, 1'b0, 1'b0, 11);
    rd(2'd0, 8'h38, "pkt3_status");
    rd(2'd1, 8'h44, "pkt3_x");
    rd(2'd2, 8'h55, "pkt3_y");
    io_cs = 1'b1;
    addr = 2'd2;
    @(negedge clk);
    io_cs = 1'b0;
    send(8'h08, 1'b0, 1'b0, 11);
    send(8'h66, 1'b1, 1'b0, 11);
`ifdef PS2_PARITY_CHECK_EN
    check("perr_no_dav", {7'd0, dav}, 8'd0);
    rd(2'd3, 8'h61, "perr_ctrl");
    send(8'h18, 1'b0, 1'b0, 11);
    send(8'h01, 1'b0, 1'b0, 11);
    send(8'h02, 1'b0, 1'b0, 11);
    check("post_perr_dav", {7'd0, dav}, 8'd1);
    rd(2'd0, 8'h18, "post_perr_status");
    rd(2'd1, 8'h01, "post_perr_x");
    rd(2'd3, 8'hE1, "post_perr_ctrl");
`else
    send(8'h77, 1'b0, 1'b0, 11);
    check("parity_ignored_dav", {7'd0, dav}, 8'd1);
    rd(2'd1, 8'h66, "parity_ignored_x");
    rd(2'd2, 8'h77, "parity_ignored_y");
    rd(2'd3, 8'hE0, "parity_ignored_ctrl");
`endif
    send(8'h08, 1'b0, 1'b0, 11);
    rst = 1'b1;
    #1;
    check("midrst_tcp", {7'd0, TCP}, 8'd0);
    check("midrst_m_ack", {7'd0, m_ack}, 8'd0);
    check("midrst_dav", {7'd0, dav}, 8'd0);
    check("midrst_t_clk", {7'd0, t_clk}, 8'd1);
    check("midrst_t_data", {7'd0, t_data}, 8'd1);
    rd(2'd0, 8'h00, "midrst_status");
    rd(2'd3, 8'h00, "midrst_ctrl");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_inhibit", {7'd0, t_clk}, 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
